// File: rtl/br_resolve_pkg.sv
// Shared types and constants for the branch-resolve slice.
package br_resolve_pkg;

  // One tracked prediction, as captured at IF1.
  typedef struct packed {
    logic [31:0] pc;
    logic        hit;
    logic [31:0] target;
  } pred_rec_t;

  // Resolve FSM encoding.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Sequential fetch increment.
  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/br_resolve_if.sv
// Front-end / EX / BTB bus seen by br_resolve.
interface br_resolve_if;
  logic        if1_valid;
  logic [31:0] if1_pc;
  logic        if1_pred_hit;
  logic [31:0] if1_pred_target;
  logic        if1_stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_is_br;
  logic        ex_taken;
  logic        btb_we;
  logic [31:0] btb_ex_pc;
  logic [31:0] btb_wtarget;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_cnt;

  // Pipeline side: drives fetch/resolve info, consumes redirects.
  modport master (
    output if1_valid, if1_pc, if1_pred_hit, if1_pred_target,
    output ex_valid, ex_pc, ex_target, ex_is_br, ex_taken,
    input  if1_stall, btb_we, btb_ex_pc, btb_wtarget,
    input  redirect, redirect_pc, mispred_cnt
  );

  // Resolver side.
  modport slave (
    input  if1_valid, if1_pc, if1_pred_hit, if1_pred_target,
    input  ex_valid, ex_pc, ex_target, ex_is_br, ex_taken,
    output if1_stall, btb_we, btb_ex_pc, btb_wtarget,
    output redirect, redirect_pc, mispred_cnt
  );
endinterface

// File: rtl/br_resolve_pred_fifo.sv
// Synchronous FIFO of in-flight predictions with a one-edge flush.
module pred_fifo
  import br_resolve_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  pred_rec_t din,
  output pred_rec_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  pred_rec_t         mem_q [DEPTH];
  pred_rec_t         mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]       count_q, count_d;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rptr_q];

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = din;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/br_resolve.sv
// Branch resolve: compares EX outcome with the oldest IF1 prediction,
// issues redirect/BTB-update pulses and flushes the wrong path.
module br_resolve
  import br_resolve_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int FLUSH_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_n,
  br_resolve_if.slave bus
);
  localparam logic [2:0] FL_CNT = 3'(FLUSH_CYCLES);

  logic [0:0]  state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        btb_we_q, btb_we_d;
  logic [31:0] btb_ex_pc_q, btb_ex_pc_d;
  logic [31:0] btb_wtarget_q, btb_wtarget_d;
  logic [15:0] mispred_cnt_q, mispred_cnt_d;

  pred_rec_t head, push_rec;
  logic      full, empty, run, push, pop;
  logic      head_hit, pc_mismatch, taken, correct, mispred;

  assign run      = (state_q == ST_RUN);
  assign pop      = bus.ex_valid & run & ~empty;
  assign push     = bus.if1_valid & run & (~full | pop);
  assign push_rec = '{pc: bus.if1_pc, hit: bus.if1_pred_hit, target: bus.if1_pred_target};

  pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (mispred),
    .push  (push),
    .pop   (pop),
    .din   (push_rec),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Outcome check: empty FIFO resolves as a predicted miss; a PC mismatch
  // against the head is always a mispredict, redirected by actual outcome.
  always_comb begin
    head_hit    = ~empty & head.hit;
    pc_mismatch = ~empty & (head.pc != bus.ex_pc);
    taken       = bus.ex_is_br & bus.ex_taken;
    correct     = taken ? (head_hit & (head.target == bus.ex_target)) : ~head_hit;
    mispred     = bus.ex_valid & run & (pc_mismatch | ~correct);
  end

  // Redirect/BTB pulses, counter and RUN/FLUSH sequencing.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_d    = mispred;
    btb_we_d      = mispred & taken;
    redirect_pc_d = redirect_pc_q;
    btb_ex_pc_d   = btb_ex_pc_q;
    btb_wtarget_d = btb_wtarget_q;
    mispred_cnt_d = mispred_cnt_q;
    if (mispred) begin
      redirect_pc_d = taken ? bus.ex_target : bus.ex_pc + PC_INC;
      if (taken) begin
        btb_ex_pc_d   = bus.ex_pc;
        btb_wtarget_d = bus.ex_target;
      end
      if (mispred_cnt_q != 16'hFFFF) mispred_cnt_d = mispred_cnt_q + 16'd1;
      state_d     = ST_FLUSH;
      flush_cnt_d = FL_CNT;
    end else if (state_q == ST_FLUSH) begin
      if (flush_cnt_q <= 3'd1) begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      flush_cnt_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      btb_we_q      <= 1'b0;
      btb_ex_pc_q   <= '0;
      btb_wtarget_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      btb_we_q      <= btb_we_d;
      btb_ex_pc_q   <= btb_ex_pc_d;
      btb_wtarget_q <= btb_wtarget_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.if1_stall   = full;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.btb_we      = btb_we_q;
  assign bus.btb_ex_pc   = btb_ex_pc_q;
  assign bus.btb_wtarget = btb_wtarget_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_br_resolve.sv
// Directed bench for br_resolve with hand-computed expectations.
module tb_br_resolve;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_pass = 0;

  br_resolve_if bif ();

  br_resolve #(.FIFO_DEPTH(8), .FLUSH_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clr();
    bif.if1_valid = 0; bif.if1_pc = 0; bif.if1_pred_hit = 0; bif.if1_pred_target = 0;
    bif.ex_valid = 0; bif.ex_pc = 0; bif.ex_target = 0; bif.ex_is_br = 0; bif.ex_taken = 0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
    bif.if1_valid = 1; bif.if1_pc = pc; bif.if1_pred_hit = hit; bif.if1_pred_target = tgt;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic [31:0] tgt, input logic br, input logic tk);
    bif.ex_valid = 1; bif.ex_pc = pc; bif.ex_target = tgt; bif.ex_is_br = br; bif.ex_taken = tk;
  endtask

  // Advance one edge, sample 1ns after it, then return inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    chk("rst_redirect", 32'(bif.redirect), 0);
    chk("rst_btb_we", 32'(bif.btb_we), 0);
    chk("rst_redirect_pc", bif.redirect_pc, 0);
    chk("rst_btb_ex_pc", bif.btb_ex_pc, 0);
    chk("rst_btb_wtarget", bif.btb_wtarget, 0);
    chk("rst_cnt", 32'(bif.mispred_cnt), 0);
    chk("rst_stall", 32'(bif.if1_stall), 0);
    rst_n = 1;

    // Correct taken prediction
    set_push(32'h1000, 1, 32'h2000); tick();
    set_ex(32'h1000, 32'h2000, 1, 1); tick();
    chk("ok_redirect", 32'(bif.redirect), 0);
    chk("ok_btb_we", 32'(bif.btb_we), 0);
    chk("ok_cnt", 32'(bif.mispred_cnt), 0);

    // Taken, predicted miss
    set_push(32'h1000, 0, 0); tick();
    set_ex(32'h1000, 32'h3000, 1, 1); tick();
    chk("tk_redirect", 32'(bif.redirect), 1);
    chk("tk_redirect_pc", bif.redirect_pc, 32'h3000);
    chk("tk_btb_we", 32'(bif.btb_we), 1);
    chk("tk_btb_ex_pc", bif.btb_ex_pc, 32'h1000);
    chk("tk_btb_wtarget", bif.btb_wtarget, 32'h3000);
    chk("tk_cnt", 32'(bif.mispred_cnt), 1);
    tick();
    chk("tk_redirect_pulse", 32'(bif.redirect), 0);
    chk("tk_btb_we_pulse", 32'(bif.btb_we), 0);
    tick();
    set_ex(32'h5555, 0, 0, 0); tick();   // empty FIFO resolves as miss, not taken: fine
    chk("tk_fifo_empty", 32'(bif.redirect), 0);

    // Not-taken, predicted hit; wrong-path pushes and EX during flush ignored
    set_push(32'h1004, 1, 32'h2000); tick();
    set_ex(32'h1004, 0, 1, 0); tick();
    chk("nt_redirect", 32'(bif.redirect), 1);
    chk("nt_redirect_pc", bif.redirect_pc, 32'h1008);
    chk("nt_btb_we", 32'(bif.btb_we), 0);
    chk("nt_cnt", 32'(bif.mispred_cnt), 2);
    set_push(32'hA000, 1, 32'hB000); tick();
    set_push(32'hA000, 1, 32'hB000); set_ex(32'h9999, 32'h7777, 1, 1); tick();
    chk("fl_ex_ignored", 32'(bif.redirect), 0);
    set_ex(32'hA000, 32'hB000, 1, 1); tick();  // empty, so taken -> mispredict
    chk("fl_push_dropped", 32'(bif.redirect), 1);
    chk("fl_redirect_pc", bif.redirect_pc, 32'hB000);
    chk("fl_cnt", 32'(bif.mispred_cnt), 3);
    tick(); tick();

    // Fill, push+pop while full, push while full dropped
    for (int i = 0; i < 8; i++) begin
      set_push(32'h100 + 32'(4*i), 0, 0); tick();
    end
    chk("full_stall", 32'(bif.if1_stall), 1);
    set_push(32'h200, 0, 0); set_ex(32'h100, 0, 0, 0); tick();
    chk("full_pushpop_stall", 32'(bif.if1_stall), 1);
    chk("full_pushpop_redirect", 32'(bif.redirect), 0);
    set_push(32'h300, 0, 0); tick();
    chk("full_9th_stall", 32'(bif.if1_stall), 1);
    for (int i = 0; i < 8; i++) begin
      set_ex((i < 7) ? 32'h104 + 32'(4*i) : 32'h200, 0, 0, 0); tick();
      chk($sformatf("drain%0d_redirect", i), 32'(bif.redirect), 0);
    end
    chk("drain_stall", 32'(bif.if1_stall), 0);
    set_ex(32'h400, 0, 0, 0); tick();
    chk("drain_empty", 32'(bif.redirect), 0);

    // PC+4 wraps
    set_push(32'hFFFF_FFFC, 1, 32'h10); tick();
    set_ex(32'hFFFF_FFFC, 0, 1, 0); tick();
    chk("wrap_redirect", 32'(bif.redirect), 1);
    chk("wrap_redirect_pc", bif.redirect_pc, 0);
    chk("wrap_cnt", 32'(bif.mispred_cnt), 4);

    // Reset during flush with redirect high
    rst_n = 0; tick();
    chk("mid_rst_redirect", 32'(bif.redirect), 0);
    chk("mid_rst_btb_we", 32'(bif.btb_we), 0);
    chk("mid_rst_redirect_pc", bif.redirect_pc, 0);
    chk("mid_rst_btb_ex_pc", bif.btb_ex_pc, 0);
    chk("mid_rst_cnt", 32'(bif.mispred_cnt), 0);
    rst_n = 1;
    set_push(32'h700, 1, 32'h800); tick();
    set_ex(32'h700, 32'h800, 1, 1); tick();
    chk("post_rst_push", 32'(bif.redirect), 0);

    // Taken with target mismatch
    set_push(32'h40, 1, 32'h80); tick();
    set_ex(32'h40, 32'h90, 1, 1); tick();
    chk("tgt_redirect_pc", bif.redirect_pc, 32'h90);
    chk("tgt_btb_we", 32'(bif.btb_we), 1);
    chk("tgt_btb_wtarget", bif.btb_wtarget, 32'h90);
    chk("tgt_cnt", 32'(bif.mispred_cnt), 1);
    tick(); tick();

    // Head PC mismatch, not taken
    set_push(32'h50, 0, 0); tick();
    set_ex(32'h60, 0, 0, 0); tick();
    chk("pcm_redirect", 32'(bif.redirect), 1);
    chk("pcm_redirect_pc", bif.redirect_pc, 32'h64);
    chk("pcm_btb_we", 32'(bif.btb_we), 0);
    chk("pcm_cnt", 32'(bif.mispred_cnt), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
